// File: rtl/core_pkg.sv
// Shared types and widths for the RV64 5-stage core.
// Decode-to-execute bundles and the skid buffer state encoding.
package core_pkg;

    localparam int XLEN    = 64;
    localparam int REG_AW  = 5;
    localparam int FUNCT_W = 4;
    localparam int ALUOP_W = 2;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic               MemtoReg;
        logic               RegWrite;
        logic               Branch;
        logic               MemWrite;
        logic               MemRead;
        logic               ALUSrc;
        logic [ALUOP_W-1:0] ALU_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [FUNCT_W-1:0] funct;
        logic [REG_AW-1:0]  rd;
        id_ex_ctrl_t        ctrl;
    } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready buffer with flush.
// SKID_EN=0 collapses it to a single entry with combinational ready.
module pipe_skid_buf
    import core_pkg::*;
#(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q;
    skid_state_e  state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_fire;
    logic         out_fire;
    logic         load_main;
    logic         load_skid;
    logic         pop_skid;

    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    if (SKID_EN) begin : g_skid
        // ready comes from state only, never from out_ready
        assign in_ready = !reset && (state_q != SKID_FULL);
    end else begin : g_single
        assign in_ready = !reset && (!out_valid || out_ready);
    end

    // next-state and load selection; flush drops both entries and the input
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            unique case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        state_d   = SKID_BUSY;
                        load_main = 1'b1;
                    end
                end
                SKID_BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire && SKID_EN) begin
                        state_d   = SKID_FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        state_d  = SKID_BUSY;
                        pop_skid = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // occupancy state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // data entries; the skid beat only ever moves into main, keeping order
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (pop_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with handshake, flush and optional skid entry.
// Side-effect control bits read as zero whenever no beat is presented.
module id_ex_stage_reg #(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int REG_AW  = core_pkg::REG_AW,
    parameter int FUNCT_W = core_pkg::FUNCT_W,
    parameter int ALUOP_W = core_pkg::ALUOP_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [FUNCT_W-1:0] in_funct,
    input  logic [REG_AW-1:0]  in_rd,
    input  logic               in_MemtoReg,
    input  logic               in_RegWrite,
    input  logic               in_Branch,
    input  logic               in_MemWrite,
    input  logic               in_MemRead,
    input  logic               in_ALUSrc,
    input  logic [ALUOP_W-1:0] in_ALU_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic [FUNCT_W-1:0] out_funct,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_MemtoReg,
    output logic               out_RegWrite,
    output logic               out_Branch,
    output logic               out_MemWrite,
    output logic               out_MemRead,
    output logic               out_ALUSrc,
    output logic [ALUOP_W-1:0] out_ALU_op
);

    typedef struct packed {
        logic               MemtoReg;
        logic               RegWrite;
        logic               Branch;
        logic               MemWrite;
        logic               MemRead;
        logic               ALUSrc;
        logic [ALUOP_W-1:0] ALU_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [FUNCT_W-1:0] funct;
        logic [REG_AW-1:0]  rd;
        ctrl_t              ctrl;
    } payload_t;

    payload_t in_pl;
    payload_t out_pl;
    logic     vld;

    assign in_pl.pc            = in_pc;
    assign in_pl.rs1_data      = in_rs1_data;
    assign in_pl.rs2_data      = in_rs2_data;
    assign in_pl.imm           = in_imm;
    assign in_pl.funct         = in_funct;
    assign in_pl.rd            = in_rd;
    assign in_pl.ctrl.MemtoReg = in_MemtoReg;
    assign in_pl.ctrl.RegWrite = in_RegWrite;
    assign in_pl.ctrl.Branch   = in_Branch;
    assign in_pl.ctrl.MemWrite = in_MemWrite;
    assign in_pl.ctrl.MemRead  = in_MemRead;
    assign in_pl.ctrl.ALUSrc   = in_ALUSrc;
    assign in_pl.ctrl.ALU_op   = in_ALU_op;

    pipe_skid_buf #(
        .W       ($bits(payload_t)),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (vld),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    assign out_valid    = vld;
    assign out_pc       = out_pl.pc;
    assign out_rs1_data = out_pl.rs1_data;
    assign out_rs2_data = out_pl.rs2_data;
    assign out_imm      = out_pl.imm;
    assign out_funct    = out_pl.funct;
    assign out_rd       = out_pl.rd;
    assign out_ALUSrc   = out_pl.ctrl.ALUSrc;
    assign out_ALU_op   = out_pl.ctrl.ALU_op;

    // a bubble must never write registers, memory or redirect the PC
    assign out_MemtoReg = vld & out_pl.ctrl.MemtoReg;
    assign out_RegWrite = vld & out_pl.ctrl.RegWrite;
    assign out_Branch   = vld & out_pl.ctrl.Branch;
    assign out_MemWrite = vld & out_pl.ctrl.MemWrite;
    assign out_MemRead  = vld & out_pl.ctrl.MemRead;

endmodule
